// File: rtl/des_sched_pkg.sv
// des_sched_pkg: shared types and constants for the DES core scheduler.
//   DES_W      : DES block / key width.
//   MODE_ENC/MODE_DEC : operation mode encoding.
//   des_tag_t  : in-flight tag {valid, id, mode}; id sized for up to 8 requesters.
//   des_id_w() : requester id width, clog2(n) with a minimum of 1.
package des_sched_pkg;

  localparam int DES_W    = 64;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                mode;
  } des_tag_t;

  function automatic int des_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/des_rsp_fifo.sv
// des_rsp_fifo: first-word-fall-through FIFO for completed DES responses.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset.
//   push_i / push_data_i : write strobe and data.
//   pop_i           : read strobe; head advances when non-empty.
//   rd_data_o       : head entry, valid whenever empty_o is low.
//   count_o, full_o, empty_o : occupancy status.
// Storage is reset so the head reads as zero after reset.
module des_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  // The credit scheme upstream must make this impossible.
  always @(posedge clk) begin
    if (rst_n) assert (!(push_i && full_o));
  end
`endif

endmodule

// File: rtl/des_core_sched.sv
// des_core_sched: shares one fixed-latency DES core between NUM_REQ requesters.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset.
//   req_valid/req_ready/req_mode     : per-requester handshake and mode (0 enc, 1 dec).
//   req_data/req_key                 : per-requester 64-bit block/key, requester i at [64*i +: 64].
//   core_in_valid/core_mode/core_data/core_key : issue port to the DES core.
//   core_out_data                    : core result, valid CORE_LAT cycles after issue.
//   rsp_valid/rsp_ready/rsp_id/rsp_mode/rsp_data : response stream.
//   busy                             : operation in flight or responses pending.
// Optional build macro DES_SCHED_PRIO_EN: requester 0 wins whenever it is valid,
// the rest share round-robin among themselves (pointer never selects 0).
// Handshakes: a transfer happens on any cycle where valid && ready are both high
// at the rising edge; a requester keeps valid and payload stable until accepted.
module des_core_sched
  import des_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CORE_LAT  = 16,
  parameter int RSP_DEPTH = 4,
  localparam int ID_W     = des_id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ*DES_W-1:0] req_data,
  input  logic [NUM_REQ*DES_W-1:0] req_key,
  output logic                     core_in_valid,
  output logic                     core_mode,
  output logic [DES_W-1:0]         core_data,
  output logic [DES_W-1:0]         core_key,
  input  logic [DES_W-1:0]         core_out_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_mode,
  output logic [DES_W-1:0]         rsp_data,
  output logic                     busy
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int FW = ID_W + 1 + DES_W;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic             hs, pop;
  logic [CW-1:0]    credit_q, credit_d;

  logic             issue_v_q, issue_mode_q;
  logic [ID_W-1:0]  issue_id_q;
  logic [DES_W-1:0] issue_data_q, issue_key_q;

  des_tag_t         tag_q [CORE_LAT];
  des_tag_t         tail;
  logic             inflight;

  logic [FW-1:0]    fifo_rd;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;

  function automatic int wrap_add(input int base, input int k, input int n);
    return (base + k >= n) ? base + k - n : base + k;
  endfunction

  // Grant depends only on req_valid and the pointer, never on credits.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
`ifdef DES_SCHED_PRIO_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
    end else begin
      // Search requesters 1..NUM_REQ-1 in a ring of NUM_REQ-1 entries.
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        if (!gnt_any &&
            req_valid[wrap_add((ptr_q == '0) ? 0 : int'(ptr_q) - 1, k, NUM_REQ - 1) + 1]) begin
          gnt_any = 1'b1;
          gnt_id  = ID_W'(wrap_add((ptr_q == '0) ? 0 : int'(ptr_q) - 1, k, NUM_REQ - 1) + 1);
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_valid[wrap_add(int'(ptr_q), k, NUM_REQ)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(wrap_add(int'(ptr_q), k, NUM_REQ));
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    req_ready[gnt_id] = gnt_any && (credit_q != '0);
  end

  assign hs  = |(req_valid & req_ready);
  assign pop = rsp_valid && rsp_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
`ifdef DES_SCHED_PRIO_EN
      if (gnt_id != '0) ptr_d = (int'(gnt_id) + 1 >= NUM_REQ) ? ID_W'(1) : gnt_id + ID_W'(1);
`else
      ptr_d = (int'(gnt_id) + 1 >= NUM_REQ) ? '0 : gnt_id + ID_W'(1);
`endif
    end
  end

  always_comb begin
    credit_d = credit_q;
    case ({hs, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      credit_q     <= CW'(RSP_DEPTH);
      issue_v_q    <= 1'b0;
      issue_mode_q <= MODE_ENC;
      issue_id_q   <= '0;
      issue_data_q <= '0;
      issue_key_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      issue_v_q <= hs;
      if (hs) begin
        issue_mode_q <= req_mode[gnt_id];
        issue_id_q   <= gnt_id;
        issue_data_q <= req_data[DES_W*gnt_id +: DES_W];
        issue_key_q  <= req_key[DES_W*gnt_id +: DES_W];
      end
    end
  end

  assign core_in_valid = issue_v_q;
  assign core_mode     = issue_mode_q;
  assign core_data     = issue_data_q;
  assign core_key      = issue_key_q;

  // Stage k carries the tag issued k+1 cycles ago, so the tail lines up
  // with core_out_data exactly CORE_LAT cycles after core_in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CORE_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= {issue_v_q, ID_MAX_W'(issue_id_q), issue_mode_q};
      for (int k = 1; k < CORE_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tail = tag_q[CORE_LAT-1];

  always_comb begin
    inflight = issue_v_q;
    for (int k = 0; k < CORE_LAT; k++) inflight = inflight | tag_q[k].valid;
  end

  des_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (FW)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tail.valid),
    .push_data_i ({tail.id[ID_W-1:0], tail.mode, core_out_data}),
    .pop_i       (pop),
    .rd_data_o   (fifo_rd),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign {rsp_id, rsp_mode, rsp_data} = fifo_rd;
  assign busy = inflight || !fifo_empty;

`ifndef SYNTHESIS
  // credit + in-flight + queued always equals RSP_DEPTH.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (credit_q <= CW'(RSP_DEPTH));
      assert (!(tail.valid && fifo_full));
      assert (int'(credit_q) + int'(fifo_count) <= RSP_DEPTH);
      assert (int'(tail.id) < NUM_REQ);
    end
  end
`endif

endmodule

// File: tb/tb_des_core_sched.sv
// tb_des_core_sched: bench for des_core_sched (NUM_REQ=3, CORE_LAT=4, RSP_DEPTH=8).
// A stand-in core computes data+key (encrypt) or data-key (decrypt) after CORE_LAT
// cycles and drives junk otherwise. A transaction-level model predicts req_ready,
// core issue, response order/timing and busy every cycle; directed sections add
// literal expectations. Build with DES_SCHED_PRIO_EN to exercise priority mode.
module tb_des_core_sched;
  import des_sched_pkg::*;

  localparam int NR    = 3;
  localparam int CL    = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;
  localparam int RW    = IDW + 1 + 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_mode;
  logic [NR*64-1:0]  req_data, req_key;
  logic              core_in_valid, core_mode;
  logic [63:0]       core_data, core_key, core_out_data;
  logic              rsp_valid, rsp_ready, rsp_mode, busy;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_data;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  des_core_sched #(.NUM_REQ(NR), .CORE_LAT(CL), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_data(req_data), .req_key(req_key),
    .core_in_valid(core_in_valid), .core_mode(core_mode),
    .core_data(core_data), .core_key(core_key), .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_mode(rsp_mode), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k,
                                          input logic m);
    return m ? (d - k) : (d + k);
  endfunction

  // Stand-in core: not reset, so late results after a reset still appear.
  logic [63:0] core_pipe [CL];
  int cyc = 0;
  always @(posedge clk) begin
    for (int i = CL - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= core_in_valid ? core_fn(core_data, core_key, core_mode)
                                  : {32'hBADC0DE0, 32'(cyc)};
  end
  assign core_out_data = core_pipe[CL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / model state
  logic [RW-1:0] exp_q[$];
  int            rdy_q[$];
  int            m_ptr = 0;
  int            m_g;
  logic [NR-1:0] m_ready;
  logic          m_rv, m_fire;
  logic          exp_cv = 1'b0, exp_cm = 1'b0;
  logic [63:0]   exp_cd = '0, exp_ck = '0;
  logic [NR-1:0] last_hs = '0;
  int            hs_cnt = 0, rsp_cnt = 0;
  int            g_log[$];

  function automatic int model_grant(input logic [NR-1:0] v, input int p);
`ifdef DES_SCHED_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < NR - 1; k++) begin
      int c;
      c = 1 + (((p == 0) ? 0 : p - 1) + k) % (NR - 1);
      if (v[c]) return c;
    end
    return -1;
`else
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
`endif
  endfunction

  // compare process: outputs sampled mid-cycle, model advanced for the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_core_in_valid", 64'(core_in_valid), 64'd0);
      chk("rst_core_mode", 64'(core_mode), 64'd0);
      chk("rst_core_data", core_data, 64'd0);
      chk("rst_core_key", core_key, 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_mode", 64'(rsp_mode), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      rdy_q.delete();
      m_ptr = 0;
      exp_cv = 1'b0; exp_cm = 1'b0; exp_cd = '0; exp_ck = '0;
      last_hs = '0;
    end else begin
      chk("core_in_valid", 64'(core_in_valid), 64'(exp_cv));
      chk("core_mode", 64'(core_mode), 64'(exp_cm));
      chk("core_data", core_data, exp_cd);
      chk("core_key", core_key, exp_ck);

      m_g = model_grant(req_valid, m_ptr);
      m_ready = '0;
      if (m_g >= 0 && exp_q.size() < DEPTH) m_ready[m_g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(m_ready));

      m_rv = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      if (m_rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0][RW-1 -: IDW]));
        chk("rsp_mode", 64'(rsp_mode), 64'(exp_q[0][64]));
        chk("rsp_data", rsp_data, exp_q[0][63:0]);
      end
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));

      if (m_rv && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      m_fire = (m_g >= 0) && m_ready[m_g];
      exp_cv = m_fire;
      if (m_fire) begin
        exp_cm = req_mode[m_g];
        exp_cd = req_data[64*m_g +: 64];
        exp_ck = req_key[64*m_g +: 64];
        exp_q.push_back({IDW'(m_g), exp_cm, core_fn(exp_cd, exp_ck, exp_cm)});
        rdy_q.push_back(cyc + 2 + CL);
`ifdef DES_SCHED_PRIO_EN
        if (m_g != 0) m_ptr = (m_g + 1 >= NR) ? 1 : m_g + 1;
`else
        m_ptr = (m_g + 1) % NR;
`endif
      end

      last_hs = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (last_hs[i]) begin
          hs_cnt++;
          g_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) rsp_cnt++;
    end
    cyc++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    // an accepted requester presents a fresh random payload
    for (int i = 0; i < NR; i++) begin
      if (last_hs[i]) begin
        req_data[64*i +: 64] = {$urandom, $urandom};
        req_key[64*i +: 64]  = {$urandom, $urandom};
        req_mode[i]          = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int t;
    req_valid = '0;
    rsp_ready = 1'b1;
    t = 0;
    while (busy && t < 60) begin
      tick();
      t++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic single_op(input int r, input logic m, input logic [63:0] d,
                           input logic [63:0] k, input logic [63:0] exp_data,
                           input string name);
    int n;
    req_data[64*r +: 64] = d;
    req_key[64*r +: 64]  = k;
    req_mode[r]          = m;
    req_valid[r]         = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (last_hs[r]) break;
    end
    req_valid[r] = 1'b0;
    chk({name, "_hs"}, 64'(last_hs[r]), 64'd1);
    n = 1;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'd6);
    chk({name, "_id"}, 64'(rsp_id), 64'(r));
    chk({name, "_mode"}, 64'(rsp_mode), 64'(m));
    chk({name, "_data"}, rsp_data, exp_data);
  endtask

  int base_hs, base_rsp;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_mode = '0; req_data = '0; req_key = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);

    // single op and decrypt round trip: 2587413 + 7469321 = 10056734
    single_op(0, MODE_ENC, 64'd2587413, 64'd7469321, 64'd10056734, "enc_req0");
    single_op(1, MODE_DEC, 64'd10056734, 64'd7469321, 64'd2587413, "dec_req1");
    drain("single_drain");

`ifdef DES_SCHED_PRIO_EN
    // priority: requester 0 wins every cycle, then requester 1 takes over
    do_reset();
    g_log.delete();
    base_hs = hs_cnt;
    req_valid = 3'b011;
    repeat (8) tick();
    chk("prio_hs_count", 64'(hs_cnt - base_hs), 64'd8);
    for (int k = 0; k < 8; k++) chk("prio_grant0", 64'(g_log[k]), 64'd0);
    req_valid[0] = 1'b0;
    tick();
    chk("prio_grant1_next", 64'(last_hs), 64'b010);
    drain("prio_drain");
`else
    // round robin: all requesters held valid, one issue per cycle
    do_reset();
    g_log.delete();
    base_hs = hs_cnt;
    base_rsp = rsp_cnt;
    req_valid = '1;
    repeat (24) tick();
    chk("rr_hs_count", 64'(hs_cnt - base_hs), 64'd24);
    for (int k = 0; k < 12; k++) chk("rr_grant_order", 64'(g_log[k]), 64'(k % 3));
    drain("rr_drain");
    chk("rr_rsp_count", 64'(rsp_cnt - base_rsp), 64'd24);
`endif

    // credits: stalled responses stop acceptance after DEPTH ops
    do_reset();
    base_hs = hs_cnt;
    base_rsp = rsp_cnt;
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (30) tick();
    chk("credit_hs_count", 64'(hs_cnt - base_hs), 64'd8);
    chk("credit_ready_low", 64'(req_ready), 64'd0);
    chk("credit_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("credit_busy", 64'(busy), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (10) tick();
    chk("credit_one_pop", 64'(hs_cnt - base_hs), 64'd9);
    // pops overlapping handshakes while credit hovers at 0/1
    rsp_ready = 1'b1;
    repeat (3) tick();
    rsp_ready = 1'b0;
    repeat (10) tick();
    chk("credit_overlap", 64'(hs_cnt - base_hs), 64'd12);
    chk("credit_ready_low2", 64'(req_ready), 64'd0);
    drain("credit_drain");
    chk("credit_rsp_count", 64'(rsp_cnt - base_rsp), 64'd12);

    // reset with three ops in flight
    do_reset();
    req_valid = '1;
    repeat (3) tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_core_valid", 64'(core_in_valid), 64'd0);
    chk("midrst_core_data", core_data, 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("midrst_busy_after", 64'(busy), 64'd0);
    base_hs = hs_cnt;
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (20) tick();
    chk("midrst_credit_restored", 64'(hs_cnt - base_hs), 64'd8);
    drain("midrst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
